// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle: opcode/flags in, enables and mux selects out.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal_op, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control FSM: Moore datapath controls plus pc_write/imm_src/illegal_op.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles; state updates on clk only.
// Backpressure: with MC_MEMWAIT_EN, FETCH/MEMREAD/MEMWRITE stall until mem_ready, else ignored.
module multicycle_ctrl_fsm (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpBeq  = 7'b1100011;

    state_t     state, nextState;
    logic       accessDone;
    logic       pcUpdate, branch, irWrite, regWrite, memWrite, adrSrc, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;

`ifdef MC_MEMWAIT_EN
    assign accessDone = bus.mem_ready;
`else
    logic unusedMemReady;
    assign unusedMemReady = bus.mem_ready;
    assign accessDone     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= nextState;
    end

    always_comb begin
        nextState = FETCH;
        pcUpdate  = 1'b0;
        branch    = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        adrSrc    = 1'b0;
        illegal   = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        case (state)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                // PC/IR only advance on the cycle the fetch actually lands
                irWrite   = accessDone;
                pcUpdate  = accessDone;
                nextState = accessDone ? DECODE : FETCH;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (bus.op)
                    OpLw, OpSw: nextState = MEMADR;
                    OpR:        nextState = EXECR;
                    OpI:        nextState = EXECI;
                    OpJal:      nextState = JAL;
                    OpBeq:      nextState = BEQ;
                    default: begin
                        nextState = FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                nextState = (bus.op == OpLw) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrSrc    = 1'b1;
                nextState = accessDone ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                adrSrc    = 1'b1;
                memWrite  = 1'b1;
                nextState = accessDone ? FETCH : MEMWRITE;
            end
            EXECR: begin
                aluSrcA   = 2'b10;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            EXECI: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                aluOp     = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                regWrite  = 1'b1;
                nextState = FETCH;
            end
            JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pcUpdate  = 1'b1;
                nextState = ALUWB;
            end
            BEQ: begin
                aluSrcA   = 2'b10;
                aluOp     = 2'b01;
                branch    = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OpSw:    immSrc = 2'b01;
            OpBeq:   immSrc = 2'b10;
            OpJal:   immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    // Reset masks every control so the datapath is quiescent while rst is held
    assign bus.pc_write   = ~rst & (pcUpdate | (branch & bus.zero));
    assign bus.ir_write   = ~rst & irWrite;
    assign bus.reg_write  = ~rst & regWrite;
    assign bus.mem_write  = ~rst & memWrite;
    assign bus.adr_src    = ~rst & adrSrc;
    assign bus.illegal_op = ~rst & illegal;
    assign bus.result_src = rst ? 2'b00 : resultSrc;
    assign bus.alu_src_a  = rst ? 2'b00 : aluSrcA;
    assign bus.alu_src_b  = rst ? 2'b00 : aluSrcB;
    assign bus.alu_op     = rst ? 2'b00 : aluOp;
    assign bus.imm_src    = rst ? 2'b00 : immSrc;
    assign bus.state_o    = state;
endmodule
